// File: rtl/mod_updown_counter.sv
// Parametrised up/down event counter with load clamp, wrap/saturate bounds and overflow flags.
// Optional enable prescaler is compiled in with `define COUNTER_PRESCALE_EN.
module mod_updown_counter #(
    parameter int WIDTH    = 5,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf_pulse,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_pulse_q, ovf_pulse_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             step;
    logic             boundary;

`ifdef COUNTER_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_TC = PW'(PRESCALE-1);

    logic [PW-1:0] presc_q, presc_d;

    // Only the enable cycle that lands on the terminal phase is a real step.
    always_comb begin
        presc_d = presc_q;
        step    = 1'b0;
        if (load) begin
            presc_d = '0;
        end else if (enable) begin
            if (presc_q == PRE_TC) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic [31:0] unused_prescale;
    assign unused_prescale = 32'(PRESCALE);
    assign step = enable & ~load;
`endif

    always_comb begin
        count_d      = count_q;
        ovf_pulse_d  = 1'b0;
        ovf_sticky_d = ovf_sticky_q & ~clr_sticky;
        boundary     = up_dn ? (count_q == MAX_C) : (count_q == '0);
        if (load) begin
            count_d = (data > MAX_C) ? MAX_C : data;
        end else if (step) begin
            ovf_pulse_d = boundary;
            if (boundary) begin
                // A boundary event sets the sticky flag even if clr_sticky is high.
                ovf_sticky_d = 1'b1;
                count_d      = sat_mode ? count_q : (up_dn ? '0 : MAX_C);
            end else begin
                count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count_q      <= '0;
            ovf_pulse_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            ovf_pulse_q  <= ovf_pulse_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign count      = count_q;
    assign ovf_pulse  = ovf_pulse_q;
    assign ovf_sticky = ovf_sticky_q;
    assign at_max     = (count_q == MAX_C);
    assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=5, MAX_VAL=23) against a modular-arithmetic model.
module tb_mod_updown_counter;

    localparam int WIDTH    = 5;
    localparam int MAX_VAL  = 23;
    localparam int PRESCALE = 4;

    logic             clk = 1'b0;
    logic             rst_ = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic             enable = 1'b0;
    logic             up_dn = 1'b0;
    logic             sat_mode = 1'b0;
    logic             clr_sticky = 1'b0;
    logic [WIDTH-1:0] count;
    logic             at_max, at_zero, ovf_pulse, ovf_sticky;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_count = 0;
    bit m_pulse = 0;
    bit m_sticky = 0;
    int m_presc = 0;

    mod_updown_counter #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst_(rst_), .load(load), .data(data), .enable(enable),
        .up_dn(up_dn), .sat_mode(sat_mode), .clr_sticky(clr_sticky),
        .count(count), .at_max(at_max), .at_zero(at_zero),
        .ovf_pulse(ovf_pulse), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_vec();
        return {5'(m_count), m_pulse, m_sticky, (m_count == MAX_VAL), (m_count == 0)};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {count, ovf_pulse, ovf_sticky, at_max, at_zero};
    endfunction

    function automatic void model_reset();
        m_count = 0; m_pulse = 0; m_sticky = 0; m_presc = 0;
    endfunction

    // Expected state after one clock edge, derived from the behavioural rules.
    function automatic void model_edge(bit ld, int d, bit en, bit up, bit sat, bit clr);
        bit ev = 0;
        bit do_step;
        if (clr) m_sticky = 0;
        if (ld) begin
            m_count = (d > MAX_VAL) ? MAX_VAL : d;
            m_presc = 0;
        end else if (en) begin
            do_step = 1;
`ifdef COUNTER_PRESCALE_EN
            do_step = (m_presc == PRESCALE - 1);
            m_presc = do_step ? 0 : m_presc + 1;
`endif
            if (do_step) begin
                ev = up ? (m_count == MAX_VAL) : (m_count == 0);
                if (!(ev && sat))
                    m_count = up ? (m_count + 1) % (MAX_VAL + 1)
                                 : (m_count + MAX_VAL) % (MAX_VAL + 1);
            end
        end
        m_pulse = ev;
        if (ev) m_sticky = 1;
    endfunction

    task automatic drive(bit ld, int d, bit en, bit up, bit sat, bit clr);
        load = ld; data = WIDTH'(d); enable = en; up_dn = up; sat_mode = sat; clr_sticky = clr;
        model_edge(ld, d, en, up, sat, clr);
        @(posedge clk);
        #1;
        load = 0; enable = 0; clr_sticky = 0;
    endtask

    task automatic test_reset();
        rst_ = 0;
        model_reset();
        #12;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset got=%b exp=%b", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst_ = 1;
    endtask

    task automatic test_wrap_up();
        for (int i = 0; i < 25; i++) begin
            drive(0, 0, 1, 1, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_up cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        drive(1, 30, 0, 1, 1, 1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL load_clamp got=%b exp=%b", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 1, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL sat_hold cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_sticky();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL down_wrap got=%b exp=%b", obs_vec(), exp_vec());
        end
        drive(0, 0, 0, 0, 0, 1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL sticky_clr got=%b exp=%b", obs_vec(), exp_vec());
        end
        drive(0, 0, 1, 1, 0, 1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL sticky_set_wins got=%b exp=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_load_priority();
        drive(1, 10, 0, 1, 0, 0);
        drive(1, 5, 1, 1, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL load_wins got=%b exp=%b", obs_vec(), exp_vec());
        end
        for (int i = 0; i < PRESCALE; i++) begin
            drive(0, 0, 1, 1, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL after_load cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1, 17, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        #2;
        rst_ = 0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst_ = 1;
        for (int i = 0; i < PRESCALE; i++) begin
            drive(0, 0, 1, 1, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL resume cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic test_prescale();
        rst_ = 0;
        model_reset();
        @(negedge clk);
        rst_ = 1;
        for (int i = 0; i < 14; i++) begin
            if (i == 6) drive(1, 0, 1, 1, 0, 0);
            else drive(0, 0, 1, 1, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL prescale cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 31), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_saturate();
        test_sticky();
        test_load_priority();
        test_async_reset();
`ifdef COUNTER_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
